// File: rtl/mdu_sched.sv
// ---------------------------------------------------------------------------
// mdu_sched: multiply/divide scheduler for the EX stage.
//
// Owns the HI/LO architectural registers. A MULT/MULTU/DIV/DIVU launched from
// the ID/EX register is evaluated combinationally on the launch edge and held
// in a pending buffer. A countdown FSM then keeps the unit busy for the
// configured latency before committing the pending result into HI/LO.
// While an op is in flight (or being launched), a D-stage MDU instruction
// raises MDUStall so the hazard unit freezes PC/IF-ID and bubbles ID/EX.
//
// Parameters
//   MULT_CYCLES  busy cycles for MULT/MULTU (>= 1)
//   DIV_CYCLES   busy cycles for DIV/DIVU   (>= 1)
//
// Ports
//   clk       in   1   clock, rising edge
//   reset     in   1   asynchronous active-low reset
//   StartE    in   1   EX instr is mult/div; launch this cycle
//   MDUOpE    in   4   1=MULT 2=MULTU 3=DIV 4=DIVU, anything else is a no-op
//   HIWriteE  in   1   mthi: HI <= RD1E
//   LOWriteE  in   1   mtlo: LO <= RD1E
//   HIReadE   in   1   mfhi in EX
//   LOReadE   in   1   mflo in EX
//   RD1E      in   32  operand A (rs, forwarded)
//   RD2E      in   32  operand B (rt, forwarded)
//   MDUUseD   in   1   D-stage instr touches the MDU
//   Busy      out  1   op in flight
//   MDUStall  out  1   stall D / flush E request
//   MDUOutE   out  32  HI if HIReadE, else LO if LOReadE, else 0
// ---------------------------------------------------------------------------
module mdu_sched #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        StartE,
    input  logic [3:0]  MDUOpE,
    input  logic        HIWriteE,
    input  logic        LOWriteE,
    input  logic        HIReadE,
    input  logic        LOReadE,
    input  logic [31:0] RD1E,
    input  logic [31:0] RD2E,
    input  logic        MDUUseD,
    output logic        Busy,
    output logic        MDUStall,
    output logic [31:0] MDUOutE
);

    // -----------------------------------------------------------------------
    // Counter sizing: the counter holds N-1 at most.
    // -----------------------------------------------------------------------
    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;

    typedef enum logic [0:0] {
        StIdle,
        StBusy
    } state_t;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    state_t           state_q;
    logic [CNT_W-1:0] count_q;
    logic [31:0]      hi_q;
    logic [31:0]      lo_q;
    logic [31:0]      pend_hi_q;
    logic [31:0]      pend_lo_q;
    logic             pend_we_q;    // cleared for divide-by-zero: HI/LO keep their value
    logic             busy_q;

    // -----------------------------------------------------------------------
    // Op decode
    // -----------------------------------------------------------------------
    logic op_valid;
    logic op_is_div;
    logic op_signed;

    always_comb begin
        op_valid  = 1'b0;
        op_is_div = 1'b0;
        op_signed = 1'b0;
        case (MDUOpE)
            OP_MULT: begin
                op_valid  = 1'b1;
                op_signed = 1'b1;
            end
            OP_MULTU: begin
                op_valid  = 1'b1;
            end
            OP_DIV: begin
                op_valid  = 1'b1;
                op_is_div = 1'b1;
                op_signed = 1'b1;
            end
            OP_DIVU: begin
                op_valid  = 1'b1;
                op_is_div = 1'b1;
            end
            default: begin
                op_valid  = 1'b0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Multiply: extend to 64 bits (sign or zero) and keep the low 64 bits of
    // the product, which equals the exact 32x32 product in either mode.
    // -----------------------------------------------------------------------
    logic [63:0] mul_a;
    logic [63:0] mul_b;
    logic [63:0] mul_prod;

    always_comb begin
        mul_a    = op_signed ? {{32{RD1E[31]}}, RD1E} : {32'd0, RD1E};
        mul_b    = op_signed ? {{32{RD2E[31]}}, RD2E} : {32'd0, RD2E};
        mul_prod = mul_a * mul_b;
    end

    // -----------------------------------------------------------------------
    // Divide: done on magnitudes so truncation toward zero and the remainder
    // sign rule fall out directly. 0x80000000 / -1 yields magnitude
    // 0x80000000 with like signs, i.e. LO=0x80000000, HI=0, with no special
    // case. A zero divisor is replaced by 1 only to keep the arithmetic
    // defined; that result is never committed.
    // -----------------------------------------------------------------------
    logic        div_by_zero;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic [31:0] div_den;
    logic [31:0] uquot;
    logic [31:0] urem;
    logic [31:0] quot;
    logic [31:0] rem;

    always_comb begin
        div_by_zero = (RD2E == 32'd0);
        a_neg       = op_signed & RD1E[31];
        b_neg       = op_signed & RD2E[31];
        abs_a       = a_neg ? (32'd0 - RD1E) : RD1E;
        abs_b       = b_neg ? (32'd0 - RD2E) : RD2E;
        div_den     = div_by_zero ? 32'd1 : abs_b;
        uquot       = abs_a / div_den;
        urem        = abs_a % div_den;
        quot        = (a_neg ^ b_neg) ? (32'd0 - uquot) : uquot;
        rem         = a_neg ? (32'd0 - urem) : urem;
    end

    // -----------------------------------------------------------------------
    // Result select for the pending buffer
    // -----------------------------------------------------------------------
    logic [31:0]      res_hi;
    logic [31:0]      res_lo;
    logic             res_we;
    logic [CNT_W-1:0] res_load;

    always_comb begin
        if (op_is_div) begin
            res_hi   = rem;
            res_lo   = quot;
            res_we   = ~div_by_zero;
            res_load = DIV_LOAD;
        end else begin
            res_hi   = mul_prod[63:32];
            res_lo   = mul_prod[31:0];
            res_we   = 1'b1;
            res_load = MULT_LOAD;
        end
    end

    // -----------------------------------------------------------------------
    // FSM, HI/LO and pending buffer.
    // Launch edge t: Busy high for t+1..t+N, commit on the edge ending t+N.
    // Any StartE (even with an invalid op) suppresses mthi/mtlo that cycle.
    // Starts and writes arriving while busy are ignored.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            count_q   <= '0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            pend_hi_q <= 32'd0;
            pend_lo_q <= 32'd0;
            pend_we_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (StartE) begin
                        if (op_valid) begin
                            pend_hi_q <= res_hi;
                            pend_lo_q <= res_lo;
                            pend_we_q <= res_we;
                            count_q   <= res_load;
                            busy_q    <= 1'b1;
                            state_q   <= StBusy;
                        end
                    end else begin
                        if (HIWriteE) begin
                            hi_q <= RD1E;
                        end
                        if (LOWriteE) begin
                            lo_q <= RD1E;
                        end
                    end
                end
                StBusy: begin
                    if (count_q == '0) begin
                        if (pend_we_q) begin
                            hi_q <= pend_hi_q;
                            lo_q <= pend_lo_q;
                        end
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end else begin
                        count_q <= count_q - 1'b1;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Outputs. MDUOutE reads the architectural HI/LO only; there is no
    // bypass from the pending buffer or from a same-cycle mthi/mtlo.
    // -----------------------------------------------------------------------
    assign Busy     = busy_q;
    assign MDUStall = MDUUseD & (StartE | busy_q);

    always_comb begin
        if (HIReadE) begin
            MDUOutE = hi_q;
        end else if (LOReadE) begin
            MDUOutE = lo_q;
        end else begin
            MDUOutE = 32'd0;
        end
    end

endmodule

// File: tb/tb_mdu_sched.sv
// ---------------------------------------------------------------------------
// tb_mdu_sched: directed self-checking bench for mdu_sched with default
// latencies (MULT 5, DIV 10). Inputs change 1ns after the rising edge and
// outputs are sampled a few ns later, well clear of the edge.
// ---------------------------------------------------------------------------
module tb_mdu_sched;

    logic        clk = 1'b0;
    logic        reset;
    logic        StartE;
    logic [3:0]  MDUOpE;
    logic        HIWriteE;
    logic        LOWriteE;
    logic        HIReadE;
    logic        LOReadE;
    logic [31:0] RD1E;
    logic [31:0] RD2E;
    logic        MDUUseD;
    logic        Busy;
    logic        MDUStall;
    logic [31:0] MDUOutE;

    int vectors     = 0;
    int miscompares = 0;

    mdu_sched #(
        .MULT_CYCLES(5),
        .DIV_CYCLES (10)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .StartE  (StartE),
        .MDUOpE  (MDUOpE),
        .HIWriteE(HIWriteE),
        .LOWriteE(LOWriteE),
        .HIReadE (HIReadE),
        .LOReadE (LOReadE),
        .RD1E    (RD1E),
        .RD2E    (RD2E),
        .MDUUseD (MDUUseD),
        .Busy    (Busy),
        .MDUStall(MDUStall),
        .MDUOutE (MDUOutE)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    // ---------------- stimulus helpers (no checking) ----------------
    task automatic idle_inputs();
        StartE   = 1'b0;
        MDUOpE   = 4'd0;
        HIWriteE = 1'b0;
        LOWriteE = 1'b0;
        HIReadE  = 1'b0;
        LOReadE  = 1'b0;
        RD1E     = 32'd0;
        RD2E     = 32'd0;
        MDUUseD  = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Takes 2ns, stays inside the current cycle.
    task automatic read_hilo(output logic [31:0] hi, output logic [31:0] lo);
        HIReadE = 1'b1;
        LOReadE = 1'b0;
        #1 hi = MDUOutE;
        HIReadE = 1'b0;
        LOReadE = 1'b1;
        #1 lo = MDUOutE;
        LOReadE = 1'b0;
    endtask

    task automatic write_hilo(input logic [31:0] hi, input logic [31:0] lo);
        HIWriteE = 1'b1;
        RD1E     = hi;
        tick();
        HIWriteE = 1'b0;
        LOWriteE = 1'b1;
        RD1E     = lo;
        tick();
        LOWriteE = 1'b0;
        RD1E     = 32'd0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [31:0] hi, lo;
        reset = 1'b0;
        idle_inputs();
        #3;
        vectors++;
        if (Busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_busy: got %b expected 0", Busy);
        end
        vectors++;
        if (MDUStall !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_stall_idle: got %b expected 0", MDUStall);
        end
        StartE  = 1'b1;
        MDUOpE  = 4'd1;
        MDUUseD = 1'b1;
        #1;
        vectors++;
        if (MDUStall !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_stall_start_use: got %b expected 1", MDUStall);
        end
        idle_inputs();
        read_hilo(hi, lo);
        vectors++;
        if (hi !== 32'd0 || lo !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_hilo: got %h/%h expected 0/0", hi, lo);
        end
        @(negedge clk);
        reset = 1'b1;
        tick();
        vectors++;
        if (Busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release_busy: got %b expected 0", Busy);
        end
    endtask

    task automatic test_arith();
        logic [3:0]  op  [8];
        logic [31:0] a   [8];
        logic [31:0] b   [8];
        int          n   [8];
        logic [31:0] ehi [8];
        logic [31:0] elo [8];
        logic [31:0] hi, lo;
        int          cycles;
        op[0] = 4'd1; a[0] = 32'hFFFF_FFFE; b[0] = 32'd3;
        n[0] = 5;  ehi[0] = 32'hFFFF_FFFF; elo[0] = 32'hFFFF_FFFA;
        op[1] = 4'd2; a[1] = 32'hFFFF_FFFF; b[1] = 32'hFFFF_FFFF;
        n[1] = 5;  ehi[1] = 32'hFFFF_FFFE; elo[1] = 32'h0000_0001;
        op[2] = 4'd3; a[2] = 32'hFFFF_FFF9; b[2] = 32'd2;
        n[2] = 10; ehi[2] = 32'hFFFF_FFFF; elo[2] = 32'hFFFF_FFFD;
        op[3] = 4'd3; a[3] = 32'h8000_0000; b[3] = 32'hFFFF_FFFF;
        n[3] = 10; ehi[3] = 32'h0000_0000; elo[3] = 32'h8000_0000;
        op[4] = 4'd3; a[4] = 32'd7; b[4] = 32'hFFFF_FFFE;
        n[4] = 10; ehi[4] = 32'h0000_0001; elo[4] = 32'hFFFF_FFFD;
        op[5] = 4'd4; a[5] = 32'd100; b[5] = 32'd7;
        n[5] = 10; ehi[5] = 32'd2; elo[5] = 32'd14;
        op[6] = 4'd4; a[6] = 32'd5; b[6] = 32'd0;
        n[6] = 10; ehi[6] = 32'h1111_1111; elo[6] = 32'h2222_2222;
        op[7] = 4'd3; a[7] = 32'd9; b[7] = 32'd0;
        n[7] = 10; ehi[7] = 32'h1111_1111; elo[7] = 32'h2222_2222;
        for (int v = 0; v < 8; v++) begin
            write_hilo(32'h1111_1111, 32'h2222_2222);
            StartE = 1'b1;
            MDUOpE = op[v];
            RD1E   = a[v];
            RD2E   = b[v];
            tick();
            idle_inputs();
            cycles = 0;
            while (Busy === 1'b1 && cycles < 40) begin
                if (cycles == 0) begin
                    read_hilo(hi, lo);
                    vectors++;
                    if (hi !== 32'h1111_1111 || lo !== 32'h2222_2222) begin
                        miscompares++;
                        $display("FAIL arith%0d_hilo_while_busy: got %h/%h expected 11111111/22222222",
                                 v, hi, lo);
                    end
                end
                tick();
                cycles++;
            end
            vectors++;
            if (cycles != n[v]) begin
                miscompares++;
                $display("FAIL arith%0d_busy_cycles: got %0d expected %0d", v, cycles, n[v]);
            end
            read_hilo(hi, lo);
            vectors++;
            if (hi !== ehi[v] || lo !== elo[v]) begin
                miscompares++;
                $display("FAIL arith%0d_result: got %h/%h expected %h/%h", v, hi, lo, ehi[v], elo[v]);
            end
        end
    endtask

    task automatic test_mdu_stall();
        int stall_cnt;
        idle_inputs();
        MDUUseD = 1'b1;
        StartE  = 1'b1;
        MDUOpE  = 4'd3;
        RD1E    = 32'd100;
        RD2E    = 32'd7;
        #1;
        vectors++;
        if (MDUStall !== 1'b1) begin
            miscompares++;
            $display("FAIL stall_launch: got %b expected 1", MDUStall);
        end
        tick();
        StartE    = 1'b0;
        stall_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (MDUStall === 1'b1) stall_cnt++;
            tick();
        end
        vectors++;
        if (stall_cnt != 10) begin
            miscompares++;
            $display("FAIL stall_busy_cycles: got %0d expected 10", stall_cnt);
        end
        #1;
        vectors++;
        if (MDUStall !== 1'b0 || Busy !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_release: got stall=%b busy=%b expected 0/0", MDUStall, Busy);
        end
        // Same op with no D-stage MDU use: never stalls.
        tick();
        MDUUseD   = 1'b0;
        StartE    = 1'b1;
        MDUOpE    = 4'd3;
        stall_cnt = 0;
        #1;
        if (MDUStall !== 1'b0) stall_cnt++;
        tick();
        StartE = 1'b0;
        for (int i = 0; i < 11; i++) begin
            #1;
            if (MDUStall !== 1'b0) stall_cnt++;
            tick();
        end
        vectors++;
        if (stall_cnt != 0) begin
            miscompares++;
            $display("FAIL stall_no_use: got %0d stall cycles expected 0", stall_cnt);
        end
        idle_inputs();
    endtask

    task automatic test_mtlo_mflo();
        logic [31:0] hi, lo;
        idle_inputs();
        LOWriteE = 1'b1;
        RD1E     = 32'h0000_1234;
        tick();
        LOWriteE = 1'b0;
        RD1E     = 32'd0;
        LOReadE  = 1'b1;
        #1;
        vectors++;
        if (MDUOutE !== 32'h0000_1234) begin
            miscompares++;
            $display("FAIL mtlo_mflo: got %h expected 00001234", MDUOutE);
        end
        LOReadE = 1'b0;
        #1;
        vectors++;
        if (MDUOutE !== 32'd0) begin
            miscompares++;
            $display("FAIL no_read_zero: got %h expected 00000000", MDUOutE);
        end
        tick();
        HIWriteE = 1'b1;
        LOWriteE = 1'b1;
        RD1E     = 32'd5;
        tick();
        idle_inputs();
        read_hilo(hi, lo);
        vectors++;
        if (hi !== 32'd5 || lo !== 32'd5) begin
            miscompares++;
            $display("FAIL mthi_mtlo_both: got %h/%h expected 5/5", hi, lo);
        end
    endtask

    task automatic test_start_wins();
        logic [31:0] hi, lo;
        int          cycles;
        write_hilo(32'h0000_000A, 32'h0000_000B);
        // DIVU by zero never commits, so any surviving write would show.
        StartE   = 1'b1;
        MDUOpE   = 4'd4;
        HIWriteE = 1'b1;
        LOWriteE = 1'b1;
        RD1E     = 32'd3;
        RD2E     = 32'd0;
        tick();
        idle_inputs();
        cycles = 0;
        while (Busy === 1'b1 && cycles < 40) begin
            tick();
            cycles++;
        end
        vectors++;
        if (cycles != 10) begin
            miscompares++;
            $display("FAIL start_wins_busy: got %0d expected 10", cycles);
        end
        read_hilo(hi, lo);
        vectors++;
        if (hi !== 32'h0000_000A || lo !== 32'h0000_000B) begin
            miscompares++;
            $display("FAIL start_wins_hilo: got %h/%h expected 0000000a/0000000b", hi, lo);
        end
    endtask

    task automatic test_busy_ignore();
        logic [31:0] hi, lo;
        int          cycles;
        write_hilo(32'h0000_0077, 32'h0000_0088);
        StartE = 1'b1;
        MDUOpE = 4'd1;
        RD1E   = 32'd6;
        RD2E   = 32'd7;
        tick();
        idle_inputs();
        cycles = 0;
        while (Busy === 1'b1 && cycles < 40) begin
            if (cycles == 2) begin
                StartE   = 1'b1;
                MDUOpE   = 4'd4;
                HIWriteE = 1'b1;
                LOWriteE = 1'b1;
                RD1E     = 32'h0000_0099;
                RD2E     = 32'd0;
            end else if (cycles == 3) begin
                idle_inputs();
                read_hilo(hi, lo);
                vectors++;
                if (hi !== 32'h0000_0077 || lo !== 32'h0000_0088) begin
                    miscompares++;
                    $display("FAIL busy_write_ignored: got %h/%h expected 00000077/00000088", hi, lo);
                end
            end
            tick();
            cycles++;
        end
        vectors++;
        if (cycles != 5) begin
            miscompares++;
            $display("FAIL busy_no_restart: got %0d busy cycles expected 5", cycles);
        end
        read_hilo(hi, lo);
        vectors++;
        if (hi !== 32'd0 || lo !== 32'd42) begin
            miscompares++;
            $display("FAIL busy_ignore_result: got %h/%h expected 0/2a", hi, lo);
        end
    endtask

    task automatic test_invalid_op();
        logic [31:0] hi, lo;
        write_hilo(32'h0000_005A, 32'h0000_00A5);
        StartE = 1'b1;
        MDUOpE = 4'd0;
        RD1E   = 32'd1;
        RD2E   = 32'd1;
        tick();
        vectors++;
        if (Busy !== 1'b0) begin
            miscompares++;
            $display("FAIL invalid_op0_busy: got %b expected 0", Busy);
        end
        MDUOpE = 4'd7;
        tick();
        vectors++;
        if (Busy !== 1'b0) begin
            miscompares++;
            $display("FAIL invalid_op7_busy: got %b expected 0", Busy);
        end
        idle_inputs();
        read_hilo(hi, lo);
        vectors++;
        if (hi !== 32'h0000_005A || lo !== 32'h0000_00A5) begin
            miscompares++;
            $display("FAIL invalid_op_hilo: got %h/%h expected 0000005a/000000a5", hi, lo);
        end
    endtask

    task automatic test_reset_mid_div();
        logic [31:0] hi, lo;
        write_hilo(32'h0000_0033, 32'h0000_0044);
        StartE = 1'b1;
        MDUOpE = 4'd3;
        RD1E   = 32'd100;
        RD2E   = 32'd7;
        tick();
        idle_inputs();
        // Count is 9 in the first busy cycle; six more edges bring it to 3.
        for (int i = 0; i < 6; i++) tick();
        vectors++;
        if (Busy !== 1'b1) begin
            miscompares++;
            $display("FAIL midreset_busy_before: got %b expected 1", Busy);
        end
        reset = 1'b0;
        #1;
        vectors++;
        if (Busy !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset_busy_async: got %b expected 0", Busy);
        end
        read_hilo(hi, lo);
        vectors++;
        if (hi !== 32'd0 || lo !== 32'd0) begin
            miscompares++;
            $display("FAIL midreset_hilo_async: got %h/%h expected 0/0", hi, lo);
        end
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 12; i++) tick();
        read_hilo(hi, lo);
        vectors++;
        if (Busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            miscompares++;
            $display("FAIL midreset_no_commit: got busy=%b %h/%h expected 0 0/0", Busy, hi, lo);
        end
    endtask

    initial begin
        test_reset();
        test_arith();
        test_mdu_stall();
        test_mtlo_mflo();
        test_start_wins();
        test_busy_ignore();
        test_invalid_op();
        test_reset_mid_div();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
